// File: rtl/microwave_cook_timer_controller.sv
// Microwave cook timer controller.
// Collects keypad time entry, counts it down on each second_tick, and drives the
// magnetron enable and end-of-cook indication. All outputs come straight from
// registers; no combinational path from inputs to outputs.
//
// Ports:
//   clock        system clock, rising edge active
//   reset        asynchronous active-low reset
//   key_valid    one-cycle strobe qualifying key_digit
//   key_digit    BCD digit from the keypad (values > 9 ignored)
//   start        one-cycle start / resume request
//   stop_clear   one-cycle pause / clear request
//   door_closed  door switch level, 1 = closed
//   second_tick  one-cycle 1 Hz enable from the divider chain
//   time_bcd     {min_tens, min_ones, sec_tens, sec_ones}
//   magnetron_on high only while cooking
//   done         high only while in the done state
//   state        IDLE=0, ENTRY=1, COOKING=2, PAUSED=3, DONE=4
module microwave_cook_timer_controller #(
  parameter int unsigned DONE_TICKS               = 3,
  parameter int unsigned QUICK_START_SECONDS_TENS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop_clear,
  input  logic        door_closed,
  input  logic        second_tick,
  output logic [15:0] time_bcd,
  output logic        magnetron_on,
  output logic        done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEntry   = 3'd1,
    StCooking = 3'd2,
    StPaused  = 3'd3,
    StDone    = 3'd4
  } state_e;

  localparam logic [15:0] QuickLoad = {8'h00, 4'(QUICK_START_SECONDS_TENS), 4'h0};
  localparam logic [3:0]  DoneLast  = 4'(DONE_TICKS - 1);

  state_e      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic        magnetron_q, done_q;

  logic        digit_ok;
  logic        start_ok;
  logic [15:0] time_shift;
  logic [15:0] time_dec;

  assign digit_ok   = key_valid && (key_digit <= 4'd9);
  assign start_ok   = start && door_closed;
  // New digit enters as sec_ones; min_tens falls off the top.
  assign time_shift = {time_q[11:0], key_digit};

  // Digit-wise BCD decrement. Seconds above 59 are not normalised: only a
  // borrow out of the seconds field reloads it with 59.
  always_comb begin
    time_dec = time_q;
    if (time_q[3:0] != 4'd0) begin
      time_dec[3:0] = time_q[3:0] - 4'd1;
    end else if (time_q[7:4] != 4'd0) begin
      time_dec[7:4] = time_q[7:4] - 4'd1;
      time_dec[3:0] = 4'd9;
    end else if (time_q[11:8] != 4'd0) begin
      time_dec[11:8] = time_q[11:8] - 4'd1;
      time_dec[7:0]  = 8'h59;
    end else if (time_q[15:12] != 4'd0) begin
      time_dec[15:12] = time_q[15:12] - 4'd1;
      time_dec[11:0]  = 12'h959;
    end
  end

  // Each branch follows the input priority: door open, stop_clear, start,
  // key_valid, second_tick.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    tick_cnt_d = tick_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (stop_clear) begin
          time_d = '0;
        end else if (start_ok) begin
          time_d  = QuickLoad;
          state_d = StCooking;
        end else if (digit_ok) begin
          time_d  = time_shift;
          state_d = StEntry;
        end
      end
      StEntry: begin
        if (stop_clear) begin
          time_d  = '0;
          state_d = StIdle;
        end else if (start_ok) begin
          if (time_q == 16'h0000) time_d = QuickLoad;
          state_d = StCooking;
        end else if (digit_ok) begin
          time_d = time_shift;
        end
      end
      StCooking: begin
        // Pausing wins over a same-cycle tick; the tick is simply lost.
        if (!door_closed || stop_clear) begin
          state_d = StPaused;
        end else if (second_tick) begin
          time_d = time_dec;
          if (time_dec == 16'h0000) begin
            state_d    = StDone;
            tick_cnt_d = '0;
          end
        end
      end
      StPaused: begin
        if (stop_clear) begin
          time_d  = '0;
          state_d = StIdle;
        end else if (start_ok) begin
          state_d = StCooking;
        end
      end
      StDone: begin
        if (!door_closed || stop_clear) begin
          state_d = StIdle;
        end else if (second_tick) begin
          if (tick_cnt_q == DoneLast) begin
            state_d = StIdle;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        time_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      time_q      <= '0;
      tick_cnt_q  <= '0;
      magnetron_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      tick_cnt_q  <= tick_cnt_d;
      magnetron_q <= (state_d == StCooking);
      done_q      <= (state_d == StDone);
    end
  end

  assign time_bcd     = time_q;
  assign magnetron_on = magnetron_q;
  assign done         = done_q;
  assign state        = state_q;

endmodule
